// File: rtl/pulse_latch.sv
// pulse_latch: single-bit set/clear latch. A cycle with pulse_in high sets
// level_out on the next rising edge; only clear brings it back to RESET_VALUE.
module pulse_latch #(
    parameter logic RESET_VALUE = 1'b0
) (
    input  logic clock,
    input  logic clear,
    input  logic pulse_in,
    output logic level_out
);

    // Declaration initializer gives the power-up value without needing clear.
    logic r_level = RESET_VALUE;
    logic w_next;

    // Next state: clear beats a simultaneous set request, which is dropped.
    // Testing clear first also keeps an unknown pulse_in from leaking out.
    always_comb begin
        w_next = r_level;
        if (clear)
            w_next = RESET_VALUE;
        else if (pulse_in)
            w_next = 1'b1;
    end

    // Single state flop; it drives the output directly, so there is no
    // combinational input-to-output path.
    always_ff @(posedge clock) begin
        r_level <= w_next;
    end

    assign level_out = r_level;

endmodule

// File: tb/tb_pulse_latch.sv
// tb_pulse_latch: drives a RESET_VALUE=0 and a RESET_VALUE=1 instance with the
// same directed and random clear/pulse_in stream and compares each against a
// history-based reference model.
module tb_pulse_latch;

    logic clock;
    logic clear;
    logic pulse_in;
    logic lvl0;
    logic lvl1;

    int n_chk = 0;
    int n_err = 0;

    // Stimulus history, one entry per rising edge already taken.
    bit hist_c[$];
    bit hist_p[$];

    pulse_latch #(.RESET_VALUE(1'b0)) u_dut0 (
        .clock     (clock),
        .clear     (clear),
        .pulse_in  (pulse_in),
        .level_out (lvl0)
    );

    pulse_latch #(.RESET_VALUE(1'b1)) u_dut1 (
        .clock     (clock),
        .clear     (clear),
        .pulse_in  (pulse_in),
        .level_out (lvl1)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic got, input logic exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%b expected=%b (cycle %0d)", tag, got, exp, hist_c.size());
        end
    endtask

    // Output is decided by the most recent edge that saw clear or pulse_in:
    // clear there -> reset value, pulse_in there -> 1, neither ever -> reset value.
    function automatic bit model(input bit rv);
        for (int k = hist_c.size() - 1; k >= 0; k--) begin
            if (hist_c[k]) return rv;
            if (hist_p[k]) return 1'b1;
        end
        return rv;
    endfunction

    // One cycle: apply inputs, check outputs mid-cycle, then take the edge.
    task automatic cyc(input bit c, input bit p);
        clear    = c;
        pulse_in = p;
        @(negedge clock);
        chk("rv0_level", lvl0, model(1'b0));
        chk("rv1_level", lvl1, model(1'b1));
        @(posedge clock);
        hist_c.push_back(c);
        hist_p.push_back(p);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0);
    endtask

    initial begin
        clear    = 1'b0;
        pulse_in = 1'b0;
        #1;
        // Power-up value with no clear ever applied.
        chk("powerup_rv0", lvl0, 1'b0);
        chk("powerup_rv1", lvl1, 1'b1);
        @(posedge clock);
        #1;

        // Idle after power-up, then a single pulse held for many cycles.
        idle(5);
        cyc(1'b0, 1'b1);
        idle(10);
        chk("single_pulse_held", lvl0, 1'b1);

        // One-cycle clear drops the level on the following cycle.
        cyc(1'b1, 1'b0);
        idle(3);
        chk("clear_drops", lvl0, 1'b0);

        // Set, then clear+pulse together: clear wins, set is not deferred.
        cyc(1'b0, 1'b1);
        idle(2);
        cyc(1'b1, 1'b1);
        cyc(1'b0, 1'b0);
        chk("clear_beats_pulse", lvl0, 1'b0);
        cyc(1'b1, 1'b1);
        cyc(1'b0, 1'b1);          // set right after clear deasserts
        idle(1);
        chk("set_after_clear", lvl0, 1'b1);

        // Multi-cycle pulse behaves like a single pulse; then clear.
        cyc(1'b1, 1'b0);
        for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1);
        idle(3);
        cyc(1'b1, 1'b0);
        idle(2);
        chk("long_pulse_cleared", lvl0, 1'b0);

        // Clear held several cycles with pulses underneath keeps the reset value.
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1);
        chk("held_clear", lvl0, 1'b0);
        cyc(1'b0, 1'b0);

        // Random mix of clear and pulse_in.
        for (int i = 0; i < 400; i++) begin
            cyc(($urandom_range(0, 5) == 0), ($urandom_range(0, 3) == 0));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
